spi_flash_master: RTL and testbench
===================================

# spi_flash_master

Parametrised SPI master for configuration and data flash access, driven one word at a time by a register or FIFO front end. Generalises the fixed byte-wide flash SPI engine: programmable word width, SCK divider, SPI mode 0 or 3, chip-select setup/hold spacing, and a valid/ready command handshake. SCK optionally leaves the FPGA through the 7-series STARTUPE2 CCLK path.

## Interface

Parameters:
- WIDTH, 8, bits per transfer word (2..32)
- DIV, 8, SCK half-period in `c` cycles (>=1)
- CPOL, 0, 0 selects SPI mode 0 (SCK idles low); 1 selects mode 3 (SCK idles high)
- CSS, 1, cycles CS_N is low before the first SCK edge (>=1)
- CSH, 1, cycles CS_N is held low after the last SCK edge when not chaining (>=1)

Ports:
- c  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- din  in  WIDTH+1  bit WIDTH = cs_hold (keep CS_N low after the word); bits WIDTH-1:0 = word to send, MSB first
- din_valid  in  1  command valid
- din_ready  out  1  engine idle, can accept a command
- dout  out  WIDTH  last received word, MSB first
- dout_valid  out  1  one-cycle pulse when dout updates
- busy  out  1  high from accept until return to IDLE
- cs_n  out  1  flash chip select
- sck  out  1  flash clock (constant CPOL when routed through STARTUPE2)
- mosi  out  1  flash data in
- miso  in  1  flash data out

## Operation

- Reset values: din_ready=0 during reset, 1 on the first cycle after; dout=0; dout_valid=0; busy=0; cs_n=1; sck=CPOL; mosi=0; state IDLE; cs_hold flag=0.
- Accept: rising edge with din_valid && din_ready. Load shift register, latch cs_hold, go to SETUP. din is ignored otherwise.
- States:
  - IDLE: din_ready=1. cs_n = ~cs_hold_flag.
  - SETUP: cs_n=0, sck=CPOL, mosi = word MSB. Lasts CSS cycles, then goes to SHIFT. Always taken, even when CS_N is already low.
  - SHIFT: WIDTH bits, each 2*DIV cycles.
    - Phase A, DIV cycles: sck=0. mosi holds the current bit.
    - Phase B, DIV cycles: sck=1.
    - In mode 3 the idle level is 1 and the first edge is falling; the phase levels are unchanged.
    - miso is registered every cycle into misoq. On the last cycle of phase B, the shift register shifts left, taking misoq into the LSB.
    - mosi advances to the next bit at the start of the next phase A.
    - After the last bit: dout <= shift register, dout_valid pulses. If cs_hold=1, go to IDLE; otherwise go to HOLD.
  - HOLD: cs_n=0, sck=CPOL for CSH cycles, then IDLE with cs_n=1.
- busy = (state != IDLE).
- Multi-word flash commands are chained by setting cs_hold=1 on every word except the last.
- din_valid asserted while not ready: no effect. The command must be held until accepted.
- Async reset mid-transfer: immediate return to reset values. cs_n rises asynchronously, aborting the flash command. No dout_valid is produced.
- Divider and bit counters wrap only through explicit reload. They have no free-running wrap.

## Timing

- Accept at edge t0. cs_n low from cycle t0+1.
- SHIFT occupies cycles t0+CSS+1 .. t0+CSS+2*DIV*WIDTH.
- dout and dout_valid are visible in cycle t0+CSS+2*DIV*WIDTH+1.
- Without hold: cs_n rises and din_ready=1 in cycle t0+CSS+2*DIV*WIDTH+CSH+1.
- With hold: din_ready=1 in cycle t0+CSS+2*DIV*WIDTH+1, with cs_n still low.
- Minimum CS_N high time between unheld commands: 1 cycle. A back-to-back accept in the first IDLE cycle is legal.
- Input MISO latency: 1 register (misoq). It is sampled DIV cycles after the SCK rising edge, which absorbs the STARTUPE2/board round trip.

## Configuration

- SPI_FLASH_STARTUPE2_EN defined:
  - A STARTUPE2 primitive is instantiated with USRCCLKO = internal sck and USRCCLKTS=0. All other STARTUPE2 inputs are tied 0 and all its outputs are unused.
  - The primitive carries the keep attribute.
  - The sck port is driven constant CPOL.
- SPI_FLASH_STARTUPE2_EN undefined: no primitive is instantiated, and sck drives the port directly.

## Structure

- Package spi_flash_pkg holds:
  - the state enum IDLE/SETUP/SHIFT/HOLD;
  - the mode constants SPI_MODE0=0 and SPI_MODE3=1;
  - the function clog2 for sizing counters.
- One sub-module, spi_flash_bit_timer: DIV-cycle phase counter with a phase A/B toggle and bit counter. It produces the phase_end and last_bit strobes.

## Test plan

- WIDTH=8, DIV=2, CPOL=0, CSS=1, CSH=1. Send din=0x09F (cs_hold=0); slave model returns 0xA5.
  - mosi carries 1,0,0,1,1,1,1,1.
  - dout=0xA5 with dout_valid at t0+34.
  - cs_n high and din_ready=1 at t0+35.
- Chain 0x103, 0x100, 0x100, 0x000 (read command plus address bytes, the last unheld).
  - cs_n stays low across all four words.
  - Exactly four dout_valid pulses.
  - cs_n rises CSH cycles after the last word.
- CPOL=1, send 0x0C3.
  - sck idles 1 before and after the transfer.
  - 8 falling-then-rising pulses.
  - Slave sampling on the rising edge receives 0xC3.
- WIDTH=16, DIV=1, send 0x0ABCD; slave returns 0x1234.
  - dout=0x1234 at t0+CSS+33.
  - din_valid pulsed while busy is ignored: no extra transfer.
- Assert rst_n low at bit 4 of a transfer.
  - cs_n=1, sck=CPOL and dout_valid=0 immediately.
  - din_ready=1 on the first cycle after release; a new 0x055 transfers correctly.
- Build with SPI_FLASH_STARTUPE2_EN.
  - The STARTUPE2 USRCCLKO toggles 16 times per 8-bit word.
  - The sck port stays constant.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// Purpose : shared types and helpers for the SPI flash master (state encoding, SPI mode constants, counter sizing).
// Latency : n/a (package only).
// Backpressure: n/a (package only).
package spi_flash_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    SHIFT = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int SPI_MODE0 = 0;
  localparam int SPI_MODE3 = 1;

  // Bits needed to count 0..value-1; never returns less than 1 so a
  // degenerate counter (value==1) still has a legal vector width.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/spi_flash_master_if.sv
// Purpose : word-level command/response channel between a register or FIFO front end and the SPI flash engine.
// Latency : n/a (wiring only).
// Backpressure: din is held by the front end until din_ready; dout_valid is a single-cycle pulse with no stall.
// Signals : din[WIDTH]=cs_hold, din[WIDTH-1:0]=word MSB first; din_valid/din_ready handshake;
//           dout/dout_valid received word; busy while a word is in flight.
interface spi_flash_master_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH:0]   din;
  logic             din_valid;
  logic             din_ready;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic             busy;

  // Front end side.
  modport master (
    output din, din_valid,
    input  din_ready, dout, dout_valid, busy
  );

  // Engine side.
  modport slave (
    input  din, din_valid,
    output din_ready, dout, dout_valid, busy
  );
endinterface

// File: rtl/spi_flash_bit_timer.sv
// Purpose : SCK phase timer: DIV-cycle phase counter, phase A/B toggle and bit counter for one SPI word.
// Latency : phase_end asserts on the DIV-th cycle of each phase; last_bit on the final cycle of the word.
// Backpressure: none; counters run while run=1 and reload to zero whenever run=0.
// Ports   : c, rst_n; run (engine in SHIFT); phase_b (0=phase A, 1=phase B);
//           phase_end (last cycle of current phase); last_bit (last cycle of phase B of the final bit).
module spi_flash_bit_timer
  import spi_flash_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 8
) (
  input  logic c,
  input  logic rst_n,
  input  logic run,
  output logic phase_b,
  output logic phase_end,
  output logic last_bit
);

  localparam int DW = clog2(DIV);
  localparam int BW = clog2(WIDTH);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  logic [DW-1:0] div_cnt;
  logic [BW-1:0] bit_cnt;

  assign phase_end = run && (div_cnt == DIV_LAST);
  assign last_bit  = phase_end && phase_b && (bit_cnt == BIT_LAST);

  // Counters only ever return to zero by explicit reload (end of phase,
  // end of word, or leaving SHIFT), never by arithmetic overflow.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      phase_b <= 1'b0;
      bit_cnt <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      phase_b <= 1'b0;
      bit_cnt <= '0;
    end else if (phase_end) begin
      div_cnt <= '0;
      phase_b <= ~phase_b;
      if (phase_b) begin
        bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_master.sv
// Purpose : parametrised SPI master (mode 0/3) moving one WIDTH-bit word per command, with CS_N setup/hold spacing.
// Latency : accept at t0 -> dout_valid at t0+CSS+2*DIV*WIDTH+1; din_ready again at that cycle (cs_hold) or +CSH.
// Backpressure: din_ready low from accept until IDLE; din_valid while not ready is ignored and must be held.
// Ports   : c, rst_n; cmd (spi_flash_master_if.slave: din/din_valid/din_ready, dout/dout_valid, busy);
//           cs_n, sck, mosi to the flash; miso from the flash.
// Build   : define SPI_FLASH_STARTUPE2_EN to route SCK through the 7-series STARTUPE2 CCLK pin
//           (the sck port is then held at the idle level).
module spi_flash_master
  import spi_flash_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV   = 8,
  parameter int CPOL  = 0,
  parameter int CSS   = 1,
  parameter int CSH   = 1
) (
  input  logic                c,
  input  logic                rst_n,
  spi_flash_master_if.slave   cmd,
  output logic                cs_n,
  output logic                sck,
  output logic                mosi,
  input  logic                miso
);

  localparam logic SCK_IDLE = (CPOL == SPI_MODE3);
  localparam int   CW       = clog2((CSS > CSH) ? CSS : CSH);
  localparam logic [CW-1:0] CSS_LOAD = CW'(CSS - 1);
  localparam logic [CW-1:0] CSH_LOAD = CW'(CSH - 1);

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;
  logic             hold_flag;
  logic             misoq;
  logic             sck_int;
  logic [CW-1:0]    cnt;
  logic             phase_b;
  logic             phase_end;
  logic             last_bit;
  logic             run;

  assign run     = (state == SHIFT);
  // Transmit bits leave from the top while received bits enter at the
  // bottom, so after WIDTH shifts sr holds the received word.
  assign sr_next = {sr[WIDTH-2:0], misoq};

  spi_flash_bit_timer #(
    .WIDTH (WIDTH),
    .DIV   (DIV)
  ) u_timer (
    .c         (c),
    .rst_n     (rst_n),
    .run       (run),
    .phase_b   (phase_b),
    .phase_end (phase_end),
    .last_bit  (last_bit)
  );

  // One register stage on MISO; it is consumed DIV cycles after the SCK
  // rising edge, leaving slack for the pad/board round trip.
  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) misoq <= 1'b0;
    else        misoq <= miso;
  end

  always_ff @(posedge c or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      sr             <= '0;
      hold_flag      <= 1'b0;
      cnt            <= '0;
      cmd.din_ready  <= 1'b0;
      cmd.dout       <= '0;
      cmd.dout_valid <= 1'b0;
      cmd.busy       <= 1'b0;
      cs_n           <= 1'b1;
      sck_int        <= SCK_IDLE;
      mosi           <= 1'b0;
    end else begin
      cmd.dout_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd.din_valid && cmd.din_ready) begin
            sr            <= cmd.din[WIDTH-1:0];
            hold_flag     <= cmd.din[WIDTH];
            cnt           <= CSS_LOAD;
            state         <= SETUP;
            cmd.din_ready <= 1'b0;
            cmd.busy      <= 1'b1;
            cs_n          <= 1'b0;
            sck_int       <= SCK_IDLE;
            mosi          <= cmd.din[WIDTH-1];
          end else begin
            cmd.din_ready <= 1'b1;
            // A chained word leaves CS_N asserted while waiting for the next.
            cs_n          <= ~hold_flag;
          end
        end

        // Taken even when CS_N is already low from a chained word, so the
        // first SCK edge is always CSS cycles after the accept.
        SETUP: begin
          if (cnt == '0) begin
            state   <= SHIFT;
            sck_int <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        SHIFT: begin
          if (phase_end) begin
            if (!phase_b) begin
              sck_int <= 1'b1;
            end else begin
              sr <= sr_next;
              if (last_bit) begin
                cmd.dout       <= sr_next;
                cmd.dout_valid <= 1'b1;
                sck_int        <= SCK_IDLE;
                mosi           <= 1'b0;
                if (hold_flag) begin
                  state         <= IDLE;
                  cmd.din_ready <= 1'b1;
                  cmd.busy      <= 1'b0;
                end else begin
                  state <= HOLD;
                  cnt   <= CSH_LOAD;
                end
              end else begin
                sck_int <= 1'b0;
                mosi    <= sr_next[WIDTH-1];
              end
            end
          end
        end

        HOLD: begin
          if (cnt == '0) begin
            state         <= IDLE;
            cs_n          <= 1'b1;
            cmd.din_ready <= 1'b1;
            cmd.busy      <= 1'b0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_FLASH_STARTUPE2_EN
  // SCK leaves on the dedicated CCLK pin; the user port is parked idle.
  (* keep = "true" *)
  STARTUPE2 #(
    .PROG_USR      ("FALSE"),
    .SIM_CCLK_FREQ (0.0)
  ) u_startup (
    .CFGCLK    (),
    .CFGMCLK   (),
    .EOS       (),
    .PREQ      (),
    .CLK       (1'b0),
    .GSR       (1'b0),
    .GTS       (1'b0),
    .KEYCLEARB (1'b0),
    .PACK      (1'b0),
    .USRCCLKO  (sck_int),
    .USRCCLKTS (1'b0),
    .USRDONEO  (1'b0),
    .USRDONETS (1'b0)
  );
  assign sck = SCK_IDLE;
`else
  assign sck = sck_int;
`endif

endmodule

// File: tb/tb_spi_flash_master.sv
// Directed bench: three engine instances (8b/DIV2 mode 0, 8b/DIV2 mode 3, 16b/DIV1 mode 0)
// each talking to a behavioural flash slave model.
module tb_spi_flash_master;

`ifdef SPI_FLASH_STARTUPE2_EN
  localparam int SCK_PORT_TOG = 0;
`else
  localparam int SCK_PORT_TOG = 16;
`endif

  logic c = 1'b0;
  logic rst_n;
  always #5 c = ~c;

  spi_flash_master_if #(.WIDTH(8))  if0 ();
  spi_flash_master_if #(.WIDTH(8))  if1 ();
  spi_flash_master_if #(.WIDTH(16)) if2 ();

  logic cs_n0, sck0, mosi0, miso0 = 1'b0;
  logic cs_n1, sck1, mosi1, miso1 = 1'b0;
  logic cs_n2, sck2, mosi2, miso2 = 1'b0;

  spi_flash_master #(.WIDTH(8), .DIV(2), .CPOL(0), .CSS(1), .CSH(1)) u0 (
    .c(c), .rst_n(rst_n), .cmd(if0), .cs_n(cs_n0), .sck(sck0), .mosi(mosi0), .miso(miso0));
  spi_flash_master #(.WIDTH(8), .DIV(2), .CPOL(1), .CSS(1), .CSH(1)) u1 (
    .c(c), .rst_n(rst_n), .cmd(if1), .cs_n(cs_n1), .sck(sck1), .mosi(mosi1), .miso(miso1));
  spi_flash_master #(.WIDTH(16), .DIV(1), .CPOL(0), .CSS(1), .CSH(1)) u2 (
    .c(c), .rst_n(rst_n), .cmd(if2), .cs_n(cs_n2), .sck(sck2), .mosi(mosi2), .miso(miso2));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Mode 0 slave for u0: drives MSB at CS fall, shifts out on falling SCK,
  // samples MOSI on rising SCK. Follows the internal SCK so it also works
  // when the port is parked behind STARTUPE2.
  logic [7:0] s0_tx = 8'h00, s0_sh = 8'h00, s0_rx = 8'h00;
  logic       s0_cs_prev = 1'b1, s0_sck_prev = 1'b0;
  int         s0_int_tog = 0, s0_port_tog = 0;
  always @(cs_n0 or u0.sck_int) begin
    if (s0_cs_prev && !cs_n0) begin
      s0_sh = s0_tx; miso0 = s0_tx[7]; s0_rx = 8'h00;
    end else if (!cs_n0 && s0_sck_prev && !u0.sck_int) begin
      s0_sh = s0_sh << 1; miso0 = s0_sh[7];
    end else if (!cs_n0 && !s0_sck_prev && u0.sck_int) begin
      s0_rx = {s0_rx[6:0], mosi0};
    end
    s0_cs_prev = cs_n0; s0_sck_prev = u0.sck_int;
  end
  always @(u0.sck_int) s0_int_tog++;
  always @(sck0) s0_port_tog++;

  // Mode 3 slave for u1: first falling edge presents the MSB.
  logic [7:0] s1_tx = 8'h00, s1_sh = 8'h00, s1_rx = 8'h00;
  logic       s1_cs_prev = 1'b1, s1_sck_prev = 1'b1;
  int         s1_rise = 0, s1_fall = 0;
  always @(cs_n1 or u1.sck_int) begin
    if (s1_cs_prev && !cs_n1) begin
      s1_sh = s1_tx; s1_rx = 8'h00; s1_rise = 0; s1_fall = 0;
    end else if (!cs_n1 && s1_sck_prev && !u1.sck_int) begin
      miso1 = s1_sh[7]; s1_sh = s1_sh << 1; s1_fall++;
    end else if (!cs_n1 && !s1_sck_prev && u1.sck_int) begin
      s1_rx = {s1_rx[6:0], mosi1}; s1_rise++;
    end
    s1_cs_prev = cs_n1; s1_sck_prev = u1.sck_int;
  end

  // Mode 0 slave for the 16-bit instance.
  logic [15:0] s2_tx = 16'h0000, s2_sh = 16'h0000, s2_rx = 16'h0000;
  logic        s2_cs_prev = 1'b1, s2_sck_prev = 1'b0;
  always @(cs_n2 or u2.sck_int) begin
    if (s2_cs_prev && !cs_n2) begin
      s2_sh = s2_tx; miso2 = s2_tx[15]; s2_rx = 16'h0000;
    end else if (!cs_n2 && s2_sck_prev && !u2.sck_int) begin
      s2_sh = s2_sh << 1; miso2 = s2_sh[15];
    end else if (!cs_n2 && !s2_sck_prev && u2.sck_int) begin
      s2_rx = {s2_rx[14:0], mosi2};
    end
    s2_cs_prev = cs_n2; s2_sck_prev = u2.sck_int;
  end

  // Each send returns #1 after the accepting edge t0, so the next negedge
  // falls in cycle t0+1.
  task automatic send0(input logic [8:0] w);
    @(negedge c); if0.din = w; if0.din_valid = 1'b1;
    @(posedge c); #1; if0.din_valid = 1'b0;
  endtask
  task automatic send1(input logic [8:0] w);
    @(negedge c); if1.din = w; if1.din_valid = 1'b1;
    @(posedge c); #1; if1.din_valid = 1'b0;
  endtask
  task automatic send2(input logic [16:0] w);
    @(negedge c); if2.din = w; if2.din_valid = 1'b1;
    @(posedge c); #1; if2.din_valid = 1'b0;
  endtask

  int cnt_on = 0, cs_hi = 0, dv_n = 0;
  task automatic tick0();
    @(negedge c);
    if (cnt_on != 0) begin
      cs_hi += int'(cs_n0);
      dv_n  += int'(if0.dout_valid);
    end
  endtask

  logic [8:0] chain_w [4];
  int tog_int, tog_port, dv2, n, n2;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    if0.din = '0; if0.din_valid = 1'b0;
    if1.din = '0; if1.din_valid = 1'b0;
    if2.din = '0; if2.din_valid = 1'b0;
    chain_w[0] = 9'h103; chain_w[1] = 9'h100; chain_w[2] = 9'h100; chain_w[3] = 9'h000;

    // ---- reset values ----
    repeat (3) @(negedge c);
    chk("rst_din_ready", if0.din_ready, 1'b0);
    chk("rst_cs_n", cs_n0, 1'b1);
    chk("rst_sck_mode0", sck0, 1'b0);
    chk("rst_sck_mode3", sck1, 1'b1);
    chk("rst_mosi", mosi0, 1'b0);
    chk("rst_busy", if0.busy, 1'b0);
    chk("rst_dout", if0.dout, 8'h00);
    chk("rst_dout_valid", if0.dout_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge c); #1;
    chk("post_rst_ready", if0.din_ready, 1'b1);
    chk("post_rst_cs_n", cs_n0, 1'b1);

    // ---- single word 0x9F, slave returns 0xA5 ----
    s0_tx = 8'hA5;
    tog_int = s0_int_tog; tog_port = s0_port_tog;
    send0(9'h09F);
    for (int k = 1; k <= 36; k++) begin
      @(negedge c);
      if (k == 1) begin
        chk("t1_cs_low", cs_n0, 1'b0);
        chk("t1_busy", if0.busy, 1'b1);
        chk("t1_ready_low", if0.din_ready, 1'b0);
        chk("t1_mosi_msb", mosi0, 1'b1);
      end
      if (k == 33) chk("t1_dv_early", if0.dout_valid, 1'b0);
      if (k == 34) begin
        chk("t1_dv", if0.dout_valid, 1'b1);
        chk("t1_dout", if0.dout, 8'hA5);
        chk("t1_cs_hold", cs_n0, 1'b0);
      end
      if (k == 35) begin
        chk("t1_cs_rise", cs_n0, 1'b1);
        chk("t1_ready", if0.din_ready, 1'b1);
        chk("t1_dv_pulse", if0.dout_valid, 1'b0);
        chk("t1_busy_end", if0.busy, 1'b0);
      end
    end
    chk("t1_mosi_bits", s0_rx, 8'h9F);
    chk("t1_usrcclk_toggles", s0_int_tog - tog_int, 16);
    chk("t1_sck_port_toggles", s0_port_tog - tog_port, SCK_PORT_TOG);

    // ---- chained read command 0x03 + 3 address bytes ----
    s0_tx = 8'h00;
    cnt_on = 0; cs_hi = 0; dv_n = 0;
    for (int i = 0; i < 4; i++) begin
      n = 0;
      tick0();
      while (!if0.din_ready && n < 200) begin tick0(); n++; end
      chk("chain_ready_wait", n < 200, 1'b1);
      if (i > 0) begin
        chk("chain_held_cs_n", cs_n0, 1'b0);
        chk("chain_held_dv", if0.dout_valid, 1'b1);
      end
      if0.din = chain_w[i]; if0.din_valid = 1'b1;
      @(posedge c); #1; if0.din_valid = 1'b0;
      cnt_on = 1;
    end
    n2 = 0;
    tick0();
    while (!if0.dout_valid && n2 < 200) begin tick0(); n2++; end
    chk("chain_last_dv_seen", n2 < 200, 1'b1);
    chk("chain_last_cs_low", cs_n0, 1'b0);
    cnt_on = 0;
    tick0();
    chk("chain_cs_rise", cs_n0, 1'b1);
    chk("chain_ready_end", if0.din_ready, 1'b1);
    chk("chain_dv_count", dv_n, 4);
    chk("chain_cs_high_cycles", cs_hi, 0);

    // ---- mode 3, send 0xC3, slave returns 0x5A ----
    chk("m3_sck_idle_before", sck1, 1'b1);
    s1_tx = 8'h5A;
    send1(9'h0C3);
    for (int k = 1; k <= 36; k++) begin
      @(negedge c);
      if (k == 1) chk("m3_cs_low", cs_n1, 1'b0);
      if (k == 34) begin
        chk("m3_dv", if1.dout_valid, 1'b1);
        chk("m3_dout", if1.dout, 8'h5A);
      end
      if (k == 35) chk("m3_cs_rise", cs_n1, 1'b1);
    end
    chk("m3_sck_idle_after", sck1, 1'b1);
    chk("m3_falls", s1_fall, 8);
    chk("m3_rises", s1_rise, 8);
    chk("m3_slave_rx", s1_rx, 8'hC3);

    // ---- 16-bit, DIV=1, send 0xABCD, slave returns 0x1234 ----
    s2_tx = 16'h1234; dv2 = 0;
    send2(17'h0ABCD);
    for (int k = 1; k <= 45; k++) begin
      @(negedge c);
      dv2 += int'(if2.dout_valid);
      if (k == 10) begin
        chk("w16_busy", if2.busy, 1'b1);
        if2.din = 17'h15555; if2.din_valid = 1'b1;
      end
      if (k == 11) if2.din_valid = 1'b0;
      if (k == 33) chk("w16_dv_early", if2.dout_valid, 1'b0);
      if (k == 34) begin
        chk("w16_dv", if2.dout_valid, 1'b1);
        chk("w16_dout", if2.dout, 16'h1234);
      end
      if (k == 35) begin
        chk("w16_cs_rise", cs_n2, 1'b1);
        chk("w16_ready", if2.din_ready, 1'b1);
      end
    end
    chk("w16_single_transfer", dv2, 1);
    chk("w16_idle_cs_n", cs_n2, 1'b1);
    chk("w16_idle_busy", if2.busy, 1'b0);
    chk("w16_dout_kept", if2.dout, 16'h1234);
    chk("w16_slave_rx", s2_rx, 16'hABCD);

    // ---- async reset during bit 4 (phase B, SCK high) ----
    s0_tx = 8'hFF;
    send0(9'h0F0);
    for (int k = 1; k <= 20; k++) @(negedge c);
    chk("rmid_busy", if0.busy, 1'b1);
    chk("rmid_sck_high", u0.sck_int, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rmid_cs_n", cs_n0, 1'b1);
    chk("rmid_sck", sck0, 1'b0);
    chk("rmid_sck_int", u0.sck_int, 1'b0);
    chk("rmid_dv", if0.dout_valid, 1'b0);
    chk("rmid_busy_clr", if0.busy, 1'b0);
    @(negedge c);
    chk("rmid_dv_in_reset", if0.dout_valid, 1'b0);
    rst_n = 1'b1;
    @(posedge c); #1;
    chk("rmid_ready_after", if0.din_ready, 1'b1);
    chk("rmid_dv_after", if0.dout_valid, 1'b0);
    s0_tx = 8'h3C;
    send0(9'h055);
    for (int k = 1; k <= 36; k++) begin
      @(negedge c);
      if (k == 34) begin
        chk("rnew_dv", if0.dout_valid, 1'b1);
        chk("rnew_dout", if0.dout, 8'h3C);
      end
      if (k == 35) chk("rnew_cs_rise", cs_n0, 1'b1);
    end
    chk("rnew_mosi_bits", s0_rx, 8'h55);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
